// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

  localparam int unsigned CountW = 7;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StPaused  = 2'd2,
    StLap     = 2'd3
  } state_e;

endpackage

// File: rtl/btn_conditioner.sv
// Raw button -> synchronised (optionally debounced) level -> one-cycle rising-edge pulse.
// Debounce filter is built only when STOPWATCH_CTRL_DEBOUNCE_EN is defined.
module btn_conditioner
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
  )
`endif
  (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic pulse_o
  );

  logic sync1_q, sync2_q;
  logic level;
  logic prev_q, pulse_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q  <= level;
      pulse_q <= level & ~prev_q;
    end
  end

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);

  logic           filt_q, filt_d;
  logic [DbW-1:0] db_cnt_q, db_cnt_d;

  // Any sample equal to the filtered level restarts the run of differing samples.
  always_comb begin
    filt_d   = filt_q;
    db_cnt_d = '0;
    if (sync2_q != filt_q) begin
      if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
        filt_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      filt_q   <= filt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign level = filt_q;
`else
  assign level = sync2_q;
`endif

  assign pulse_o = pulse_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: button conditioning, run/pause/lap FSM, prescaler and wrapping counter.
// Define STOPWATCH_CTRL_DEBOUNCE_EN to add a counter debounce filter on each button.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_DIV         = 1000000,
  parameter int unsigned MAX_COUNT       = 99,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_start_stop,
  input  logic              btn_lap,
  input  logic              btn_clear,
  output logic [CountW-1:0] count,
  output logic [CountW-1:0] disp_value,
  output logic [1:0]        state,
  output logic              running,
  output logic              tick,
  output logic              wrap
);

  localparam int unsigned       PrescW     = $clog2(CLK_DIV);
  localparam logic [PrescW-1:0] PrescLast  = PrescW'(CLK_DIV - 1);
  localparam logic [CountW-1:0] CountMax   = CountW'(MAX_COUNT);

  if (CLK_DIV < 2 || MAX_COUNT > 127 || DEBOUNCE_CYCLES < 1) begin : g_bad_param
    $error("stopwatch_ctrl: parameter out of range");
  end

  logic ss_ev, lap_ev, clr_ev;

`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_ss (
    .clk(clk), .reset(reset), .btn_i(btn_start_stop), .pulse_o(ss_ev)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_lap (
    .clk(clk), .reset(reset), .btn_i(btn_lap), .pulse_o(lap_ev)
  );
  btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_clr (
    .clk(clk), .reset(reset), .btn_i(btn_clear), .pulse_o(clr_ev)
  );
`else
  btn_conditioner u_btn_ss (
    .clk(clk), .reset(reset), .btn_i(btn_start_stop), .pulse_o(ss_ev)
  );
  btn_conditioner u_btn_lap (
    .clk(clk), .reset(reset), .btn_i(btn_lap), .pulse_o(lap_ev)
  );
  btn_conditioner u_btn_clr (
    .clk(clk), .reset(reset), .btn_i(btn_clear), .pulse_o(clr_ev)
  );
`endif

  state_e              state_q, state_d;
  logic [PrescW-1:0]   presc_q, presc_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [CountW-1:0]   lap_q, lap_d;
  logic                run, term;

  assign run  = (state_q == StRunning) || (state_q == StLap);
  assign term = run && (presc_q == PrescLast);

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    lap_d   = lap_q;

    // The tick on a terminal cycle is honoured even if the state changes on this edge.
    if (run) begin
      if (term) begin
        presc_d = '0;
        count_d = (count_q == CountMax) ? '0 : count_q + CountW'(1);
      end else begin
        presc_d = presc_q + PrescW'(1);
      end
    end

    // start_stop > clear > lap: lap only acts when no higher event is present.
    case (state_q)
      StIdle: begin
        if (ss_ev) state_d = StRunning;
      end
      StRunning: begin
        if (ss_ev) begin
          state_d = StPaused;
        end else if (lap_ev && !clr_ev) begin
          state_d = StLap;
          lap_d   = count_q;
        end
      end
      StLap: begin
        if (ss_ev) begin
          state_d = StPaused;
        end else if (lap_ev && !clr_ev) begin
          state_d = StRunning;
        end
      end
      StPaused: begin
        if (ss_ev) begin
          state_d = StRunning;
        end else if (clr_ev) begin
          state_d = StIdle;
          count_d = '0;
          presc_d = '0;
          lap_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      presc_q <= '0;
      count_q <= '0;
      lap_q   <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      count_q <= count_d;
      lap_q   <= lap_d;
    end
  end

  assign count      = count_q;
  assign disp_value = (state_q == StLap) ? lap_q : count_q;
  assign state      = state_q;
  assign running    = run;
  assign tick       = term;
  assign wrap       = term && (count_q == CountMax);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed self-checking bench for stopwatch_ctrl (CLK_DIV=4, MAX_COUNT=99, DEBOUNCE_CYCLES=16).
module tb_stopwatch_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_start_stop, btn_lap, btn_clear;
  logic [6:0] count, disp_value;
  logic [1:0] state;
  logic       running, tick, wrap;

  int checks = 0;
  int errors = 0;

  stopwatch_ctrl #(
    .CLK_DIV(4),
    .MAX_COUNT(99),
    .DEBOUNCE_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_start_stop(btn_start_stop),
    .btn_lap(btn_lap),
    .btn_clear(btn_clear),
    .count(count),
    .disp_value(disp_value),
    .state(state),
    .running(running),
    .tick(tick),
    .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mask bit0 = start_stop, bit1 = lap, bit2 = clear
  task automatic press(input logic [2:0] mask, input int hold);
    @(posedge clk);
    #1;
    btn_start_stop = mask[0];
    btn_lap        = mask[1];
    btn_clear      = mask[2];
    repeat (hold) @(posedge clk);
    #1;
    btn_start_stop = 1'b0;
    btn_lap        = 1'b0;
    btn_clear      = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL %s count: got %0d expected 0", tag, count); end
    checks++; if (disp_value !== 7'd0) begin errors++; $display("FAIL %s disp_value: got %0d expected 0", tag, disp_value); end
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL %s state: got %0d expected 0", tag, state); end
    checks++; if (running !== 1'b0) begin errors++; $display("FAIL %s running: got %0b expected 0", tag, running); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL %s tick: got %0b expected 0", tag, tick); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL %s wrap: got %0b expected 0", tag, wrap); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_start_stop = 1'b0;
    btn_lap = 1'b0;
    btn_clear = 1'b0;
    #2;
    check_zero("reset");
    cycles(2);
    reset = 1'b0;
    cycles(2);
  endtask

  task automatic test_start_run();
    bit found = 0;
    int ticks = 0;
    int misplaced = 0;
    @(posedge clk);
    #1;
    btn_start_stop = 1'b1;  // held long: must give a single event
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (state === 2'd1) begin
        found = 1;
        break;
      end
    end
    checks++; if (!found) begin errors++; $display("FAIL start_enter: got state %0d expected 1", state); end
    for (int i = 0; i < 40; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 10) btn_start_stop = 1'b0;
      if (tick === 1'b1) begin
        ticks++;
        if (i % 4 != 3) misplaced++;
      end
    end
    checks++; if (ticks != 10) begin errors++; $display("FAIL run_ticks: got %0d expected 10", ticks); end
    checks++; if (misplaced != 0) begin errors++; $display("FAIL tick_period: got %0d off-phase expected 0", misplaced); end
    checks++; if (count !== 7'd9) begin errors++; $display("FAIL run_count: got %0d expected 9", count); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL run_running: got %0b expected 1", running); end
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL held_single_event: got state %0d expected 1", state); end
  endtask

  task automatic test_wrap();
    bit reached = 0;
    bit early_wrap = 0;
    bit ticked = 0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (wrap === 1'b1) early_wrap = 1;
      if (count === 7'd99) begin
        reached = 1;
        break;
      end
    end
    checks++; if (!reached) begin errors++; $display("FAIL wrap_reach99: got %0d expected 99", count); end
    checks++; if (early_wrap) begin errors++; $display("FAIL wrap_early: got 1 expected 0"); end
    for (int k = 0; k < 5; k++) begin
      if (tick === 1'b1) begin
        ticked = 1;
        break;
      end
      @(negedge clk);
    end
    checks++; if (!ticked) begin errors++; $display("FAIL wrap_tick: got 0 expected 1"); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wrap_pulse: got %0b expected 1", wrap); end
    @(negedge clk);
    checks++; if (count !== 7'd0) begin errors++; $display("FAIL wrap_zero: got %0d expected 0", count); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_one_cycle: got %0b expected 0", wrap); end
  endtask

  task automatic test_lap();
    bit reached = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (count === 7'd4) begin
        reached = 1;
        break;
      end
    end
    checks++; if (!reached) begin errors++; $display("FAIL lap_reach4: got %0d expected 4", count); end
    press(3'b010, 2);
    cycles(3);
    checks++; if (state !== 2'd3) begin errors++; $display("FAIL lap_enter: got state %0d expected 3", state); end
    checks++; if (disp_value !== 7'd5) begin errors++; $display("FAIL lap_capture: got %0d expected 5", disp_value); end
    cycles(8);
    checks++; if (count !== 7'd7) begin errors++; $display("FAIL lap_count_adv: got %0d expected 7", count); end
    checks++; if (disp_value !== 7'd5) begin errors++; $display("FAIL lap_frozen: got %0d expected 5", disp_value); end
    press(3'b010, 2);
    cycles(3);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL lap_exit: got state %0d expected 1", state); end
    checks++; if (disp_value !== 7'd8) begin errors++; $display("FAIL lap_track: got %0d expected 8", disp_value); end
    cycles(4);
    checks++; if (disp_value !== 7'd9) begin errors++; $display("FAIL lap_track2: got %0d expected 9", disp_value); end
  endtask

  task automatic test_pause_clear();
    press(3'b001, 2);
    cycles(3);
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL pause_enter: got state %0d expected 2", state); end
    checks++; if (count !== 7'd10) begin errors++; $display("FAIL pause_count: got %0d expected 10", count); end
    cycles(10);
    checks++; if (count !== 7'd10) begin errors++; $display("FAIL pause_hold: got %0d expected 10", count); end
    checks++; if (tick !== 1'b0) begin errors++; $display("FAIL pause_tick: got %0b expected 0", tick); end
    // Clear and start together: start wins; prescaler resumes at its held terminal value.
    press(3'b101, 2);
    cycles(3);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL prio_state: got %0d expected 1", state); end
    checks++; if (count !== 7'd10) begin errors++; $display("FAIL prio_count: got %0d expected 10", count); end
    checks++; if (tick !== 1'b1) begin errors++; $display("FAIL resume_presc: got %0b expected 1", tick); end
    cycles(1);
    checks++; if (count !== 7'd11) begin errors++; $display("FAIL resume_count: got %0d expected 11", count); end
    press(3'b001, 2);
    cycles(3);
    checks++; if (count !== 7'd12 || state !== 2'd2) begin
      errors++; $display("FAIL pause2: got count %0d state %0d expected 12 2", count, state);
    end
    press(3'b100, 2);
    cycles(3);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL clear_state: got %0d expected 0", state); end
    checks++; if (count !== 7'd0 || disp_value !== 7'd0) begin
      errors++; $display("FAIL clear_count: got %0d/%0d expected 0/0", count, disp_value);
    end
    press(3'b010, 2);
    cycles(3);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL idle_lap_ignored: got %0d expected 0", state); end
  endtask

  task automatic test_reset_mid();
    bit reached = 0;
    press(3'b001, 2);
    cycles(3);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (count === 7'd37) begin
        reached = 1;
        break;
      end
    end
    checks++; if (!reached) begin errors++; $display("FAIL rst_reach37: got %0d expected 37", count); end
    cycles(2);
    #2;
    reset = 1'b1;
    #1;
    check_zero("reset_mid");
    @(negedge clk);
    reset = 1'b0;
    cycles(20);
    checks++; if (count !== 7'd0 || state !== 2'd0) begin
      errors++; $display("FAIL post_reset_idle: got count %0d state %0d expected 0 0", count, state);
    end
    press(3'b001, 2);
    cycles(3);
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL post_reset_start: got %0b expected 1", running); end
  endtask

  task automatic test_debounce();
    press(3'b001, 10);
    cycles(40);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL glitch_state: got %0d expected 0", state); end
    checks++; if (running !== 1'b0 || count !== 7'd0) begin
      errors++; $display("FAIL glitch_idle: got running %0b count %0d expected 0 0", running, count);
    end
    press(3'b001, 20);
    cycles(30);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL press_state: got %0d expected 1", state); end
    checks++; if (running !== 1'b1) begin errors++; $display("FAIL press_running: got %0b expected 1", running); end
    cycles(40);
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL press_single: got %0d expected 1", state); end
    checks++; if (count === 7'd0) begin errors++; $display("FAIL press_counting: got %0d expected nonzero", count); end
  endtask

  initial begin
    test_reset();
`ifdef STOPWATCH_CTRL_DEBOUNCE_EN
    test_debounce();
`else
    test_start_run();
    test_wrap();
    test_lap();
    test_pause_clear();
    test_reset_mid();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
